// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and memory-wait freeze
// for the five-stage OTTER core, with saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic [4:0]       EX_rd_addr,
  input  logic             EX_mem_read,
  input  logic             EX_reg_write,
  input  logic             EX_branch_taken,
  input  logic             MEM_busy,
  input  logic             cnt_clear,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0]       SCNT_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {RUN, STALL} state_t;

  state_t     state, state_nxt;
  logic [2:0] scnt, scnt_nxt;
  logic       luh, stall_inc, flush_inc;

  assign luh = EX_mem_read & EX_reg_write & (EX_rd_addr != 5'd0) &
               ((ID_rs1_used & (ID_rs1_addr == EX_rd_addr)) |
                (ID_rs2_used & (ID_rs2_addr == EX_rd_addr)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
    end
  end

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_write  = 1'b1;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    state_nxt    = state;
    scnt_nxt     = scnt;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    // Reset forces the defaults combinationally so an async reset mid-stall releases at once
    if (RST) begin
      state_nxt = RUN;
    end else if (MEM_busy) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      stall_inc    = 1'b1;
    end else if (state == RUN) begin
      if (EX_branch_taken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (luh) begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
        stall_inc   = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state_nxt = STALL;
          scnt_nxt  = SCNT_INIT;
        end
      end
    end else begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      stall_inc   = 1'b1;
      scnt_nxt    = scnt - 3'd1;
      if (scnt == 3'd1) state_nxt = RUN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (cnt_clear) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_inc && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_ONE;
      if (flush_inc && (flush_count != '1))  flush_count  <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the five-stage OTTER core. It sits beside the decode stage, upstream of the forwarding unit. It detects load-use hazards that forwarding cannot cover, taken-branch control hazards, and data-memory wait, and drives the per-stage register write enables and flushes that keep the forwarding unit's EX operands valid. It also keeps saturating performance counters for stall cycles and flush events.

## Interface
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.
- CNT_W, 16, width of each performance counter.

- CLK  in  1  core clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- ID_rs1_addr  in  5  rs1 of the instruction in decode.
- ID_rs2_addr  in  5  rs2 of the instruction in decode.
- ID_rs1_used  in  1  decode instruction reads rs1.
- ID_rs2_used  in  1  decode instruction reads rs2.
- EX_rd_addr  in  5  rd of the instruction in execute.
- EX_mem_read  in  1  execute instruction is a load.
- EX_reg_write  in  1  execute instruction writes rd.
- EX_branch_taken  in  1  branch/jump in execute resolved taken.
- MEM_busy  in  1  data memory not ready; the pipeline must freeze.
- cnt_clear  in  1  synchronous clear of both counters.
- PC_write  out  1  PC register enable.
- IF_ID_write  out  1  IF/ID register enable.
- ID_EX_write  out  1  ID/EX register enable.
- EX_MEM_write  out  1  EX/MEM register enable.
- MEM_WB_write  out  1  MEM/WB register enable.
- IF_ID_flush  out  1  load NOP into IF/ID.
- ID_EX_flush  out  1  load bubble (all control zero) into ID/EX.
- stall_cycles  out  CNT_W  saturating count of cycles with PC_write=0.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

## Operation
- **Hazard term:** luh = EX_mem_read & EX_reg_write & (EX_rd_addr != 0) & ((ID_rs1_used & ID_rs1_addr == EX_rd_addr) | (ID_rs2_used & ID_rs2_addr == EX_rd_addr)).
- **FSM states:** RUN and STALL. A 3-bit down-counter scnt is valid only in STALL.
- **Default outputs:** all five *_write = 1, both flushes = 0.
- **Priority** (highest first): MEM_busy, then EX_branch_taken (RUN only), then luh (RUN only), then STALL behaviour.
- **MEM_busy=1**, in any state:
  - All five *_write = 0.
  - Flushes = 0.
  - State and scnt hold.
  - stall_cycles increments.
- **RUN & EX_branch_taken:**
  - IF_ID_flush = 1, ID_EX_flush = 1.
  - PC_write = 1, so the PC loads the target.
  - flush_count increments.
  - State stays RUN.
  - A luh in the same cycle is ignored, because the younger instruction is discarded.
- **RUN & luh:**
  - PC_write = 0, IF_ID_write = 0, ID_EX_flush = 1.
  - stall_cycles increments.
  - If LOAD_STALL_CYCLES = 1, state stays RUN.
  - Otherwise next state is STALL with scnt = LOAD_STALL_CYCLES-1.
- **STALL:**
  - Outputs are the same as for RUN & luh.
  - scnt decrements each cycle.
  - When scnt = 1, next state is RUN.
  - EX holds a bubble, so EX_branch_taken and luh are don't-care.
- **Counters:**
  - Each counter saturates at 2^CNT_W-1.
  - cnt_clear has priority over increment; the cleared value is 0 on the next edge.

## Timing
- **Output path:** outputs are combinational from state, scnt and the current inputs. A hazard is acted on in the same cycle it is presented. No added latency.
- **Edge updates:** state, scnt and the counters update on the CLK rising edge.
- **Reset (RST high):**
  - State = RUN, scnt = 0, both counters = 0.
  - Outputs are forced to the defaults (all writes 1, flushes 0), regardless of inputs.
  - Reset asserted mid-STALL aborts the stall immediately.
  - After release, the first edge evaluates RUN.
- **Stall length:** a load-use hazard holds PC/IF_ID for exactly LOAD_STALL_CYCLES non-busy cycles. MEM_busy cycles extend the stall without consuming scnt.
- **Back-to-back hazards:** back-to-back taken branches flush on consecutive cycles, and each increments flush_count.

## Test plan
- **Load-use, rs1, LOAD_STALL_CYCLES=1:**
  - Stimulus: EX_mem_read=1, EX_reg_write=1, EX_rd_addr=5, ID_rs1_addr=5, ID_rs1_used=1.
  - Required response, same cycle: PC_write=0, IF_ID_write=0, ID_EX_flush=1.
  - Next cycle, with EX inputs cleared: all defaults; stall_cycles=1.
- **x0 and unused operand:**
  - Stimulus: a load with EX_rd_addr=0 matching rs1, then EX_rd_addr=7 matching rs2 with ID_rs2_used=0.
  - Required response: no stall in either case; outputs stay at defaults.
- **Branch vs load-use:**
  - Stimulus: EX_branch_taken=1 together with a valid luh.
  - Required response: IF_ID_flush=1, ID_EX_flush=1, PC_write=1; flush_count 0→1; stall_cycles unchanged.
- **LOAD_STALL_CYCLES=3 with MEM_busy:**
  - Stimulus: luh, then MEM_busy=1 for 2 cycles on the second stall cycle.
  - Required response: PC_write stays 0 for 5 cycles; all *_write=0 during busy; return to RUN after the 3rd non-busy stall cycle; stall_cycles=5.
- **Saturation and clear:**
  - Setup: CNT_W=4.
  - Stimulus: 20 consecutive luh cycles.
  - Required response: stall_cycles holds at 15; cnt_clear=1 gives 0 on the next edge.
- **Async reset mid-STALL:**
  - Stimulus: assert RST between clock edges while in STALL.
  - Required response: outputs return to defaults immediately; counters = 0; first post-reset cycle with no hazard shows RUN behaviour.
